imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single read port of the instruction memory bank (8-bit byte address, 32-bit word) between two requesters: the pipeline fetch stage and a debug/trace reader.
- Sequences each access: registers the address, holds it with the read enable for READ_LAT cycles, captures the word, and returns a one-cycle response to the winning requester.
- Fetch has fixed priority, with anti-starvation for debug and fetch-response cancellation on pipeline flush.

Parameters:
- ADDR_W, 8, byte address width (memory shifts right by 2 internally).
- DATA_W, 32, instruction word width.
- READ_LAT, 2, cycles mem_read/mem_addr are held before mem_rdata is sampled; legal range 1..15.
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which debug wins; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req_valid  in  1  fetch request.
- f_req_addr  in  ADDR_W  fetch byte address.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_flush  in  1  cancel outstanding fetch response.
- f_rsp_valid  out  1  fetch response pulse.
- f_rsp_data  out  DATA_W  fetch instruction word.
- d_req_valid  in  1  debug request.
- d_req_addr  in  ADDR_W  debug byte address.
- d_req_ready  out  1  debug request accepted this cycle.
- d_rsp_valid  out  1  debug response pulse.
- d_rsp_data  out  DATA_W  debug word.
- mem_read  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction outstanding (state WAIT).

Behaviour:
- Reset values: all outputs 0; state IDLE; latency counter 0; starve counter 0; owner = fetch; data register 0.
- States:
  - IDLE: no transaction.
  - WAIT: memory access in flight; latency counter runs.
  - RESP: one cycle; the response pulse is driven.
- Transitions: IDLE→WAIT on handshake; WAIT→RESP when the counter reaches READ_LAT; RESP→WAIT on handshake, otherwise RESP→IDLE.
- Acceptance: allowed in IDLE and RESP only.
  - Ready is combinational: asserted only for the arbitration winner whose valid is high.
  - Handshake = valid & ready. Ready is always 0 in WAIT.
- Arbitration:
  - Debug wins if starve counter == STARVE_LIMIT, or if f_req_valid is low.
  - Otherwise fetch wins.
  - Exactly one ready may be high per cycle.
- Starve counter:
  - +1 each accepting cycle in which d_req_valid=1 and debug is not granted; saturates at STARVE_LIMIT.
  - Cleared on debug grant, or in any cycle with d_req_valid=0.
  - Holds during WAIT.
- Timing for a handshake in cycle N:
  - mem_addr = request address and mem_read = 1 during cycles N+1..N+READ_LAT.
  - mem_rdata is sampled at the end of cycle N+READ_LAT.
  - The owner's rsp_valid is high in cycle N+READ_LAT+1 (the RESP cycle).
  - Back-to-back throughput: one access per READ_LAT+1 cycles.
- Outside WAIT: mem_read = 0 and mem_addr holds its last value.
- Response data:
  - f_rsp_data and d_rsp_data both come from the single data register.
  - Meaningful only while the corresponding valid is high; the register holds until the next capture.
- Misaligned addresses (addr[1:0] ≠ 0) are forwarded unchanged; no error is flagged.
- Flush:
  - f_flush=1 in any WAIT cycle of a fetch-owned transaction sets a kill flag. The access completes, but f_rsp_valid is suppressed in RESP.
  - f_flush in the handshake cycle does not kill the request accepted that cycle.
  - f_flush in the RESP cycle has no effect on that response.
  - f_flush has no effect on debug-owned transactions. The kill flag clears on the next handshake.
- Reset mid-transaction: the next edge returns to IDLE with mem_read=0; no response is issued for the in-flight access.

Decomposition:
- Package imem_arb_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - owner constants OWN_FETCH=0, OWN_DBG=1;
  - default parameter constants.
- One natural sub-module, imem_starve_ctr: the saturating starvation counter, with inputs inc/clr and output limit_hit.

Test Plan:
- Memory word0=0x200f0008, word1=0xac0f0000 (READ_LAT=2). Fetch addr 0x00 accepted cycle 0 → mem_read=1/mem_addr=0x00 in cycles 1–2; f_rsp_valid=1 with f_rsp_data=0x200f0008 in cycle 3; d_rsp_valid=0.
- Back-to-back: fetch addr 0x00 then 0x04 held valid → handshakes in cycles 0 and 3; responses 0x200f0008 in cycle 3 and 0xac0f0000 in cycle 6.
- Fetch and debug both continuously valid, STARVE_LIMIT=4 → debug granted after four lost accepting cycles; starve counter cleared; fetch regains priority next arbitration.
- Fetch addr 0x04 accepted, f_flush=1 in cycle 1 → mem_read still high in cycles 1–2; f_rsp_valid stays 0 in cycle 3; new fetch accepted in cycle 3 returns normally.
- Debug addr 0x05 (misaligned) with fetch idle → mem_addr=0x05; d_rsp_valid in cycle 3 with word1 data.
- reset=1 in cycle 1 of an access → cycle 2: mem_read=0, state IDLE, no response pulse; all outputs 0.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// The counter width bounds READ_LAT and STARVE_LIMIT to 1..15.
package imem_arb_pkg;

    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_READ_LAT     = 2;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DBG   = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] lim);
        return (val >= lim) ? lim : val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of accepting cycles in which a waiting debug request lost
// arbitration; limit_hit forces the next grant to debug.
module imem_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = sat_inc(cnt_q, LIMIT_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory read port between fetch (priority) and debug,
// sequencing each access through IDLE -> WAIT (READ_LAT cycles) -> RESP.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LAT     = DEF_READ_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_req_ready,
    input  logic              f_flush,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(READ_LAT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  lat_q,   lat_d;
    logic              owner_q, owner_d;
    logic              kill_q,  kill_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    logic accepting;
    logic dbg_wins;
    logic limit_hit;
    logic f_hs;
    logic d_hs;
    logic hs;

    // Debug wins when fetch is absent or debug has starved long enough.
    assign accepting   = (state_q != ST_WAIT);
    assign dbg_wins    = limit_hit | ~f_req_valid;
    assign f_req_ready = accepting & f_req_valid & ~dbg_wins;
    assign d_req_ready = accepting & d_req_valid & dbg_wins;
    assign f_hs        = f_req_valid & f_req_ready;
    assign d_hs        = d_req_valid & d_req_ready;
    assign hs          = f_hs | d_hs;

    imem_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (accepting & d_req_valid & ~d_hs),
        .clr       (~d_req_valid | d_hs),
        .limit_hit (limit_hit)
    );

    always_comb begin
        // NOTE: every next-state variable takes its current value first so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        lat_d   = lat_q;
        owner_d = owner_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (hs) begin
                    state_d = ST_WAIT;
                    lat_d   = CNT_W'(1);
                    owner_d = d_hs ? OWN_DBG : OWN_FETCH;
                    kill_d  = 1'b0;
                    addr_d  = d_hs ? d_req_addr : f_req_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if ((owner_q == OWN_FETCH) && f_flush) begin
                    kill_d = 1'b1;
                end
                // Last held cycle: the word is valid at this edge.
                if (lat_q == LAT_C) begin
                    state_d = ST_RESP;
                    lat_d   = '0;
                    data_d  = mem_rdata;
                end else begin
                    lat_d = lat_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            owner_q <= OWN_FETCH;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_read    = (state_q == ST_WAIT);
    assign busy        = (state_q == ST_WAIT);
    assign mem_addr    = addr_q;
    assign f_rsp_valid = (state_q == ST_RESP) & (owner_q == OWN_FETCH) & ~kill_q;
    assign d_rsp_valid = (state_q == ST_RESP) & (owner_q == OWN_DBG);
    assign f_rsp_data  = data_q;
    assign d_rsp_data  = data_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// reference model of the arbiter.
module tb_imem_port_arbiter;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 32;
    localparam int READ_LAT     = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_req_valid;
    logic [ADDR_W-1:0] f_req_addr;
    logic              f_req_ready;
    logic              f_flush;
    logic              f_rsp_valid;
    logic [DATA_W-1:0] f_rsp_data;
    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    always #5 clk = ~clk;

    imem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LAT     (READ_LAT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_flush     (f_flush),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_data  (f_rsp_data),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    // Memory returns the true word only in the last held cycle of a read.
    logic [DATA_W-1:0] mem [64];
    int rd_run;
    always @(posedge clk) rd_run <= mem_read ? rd_run + 1 : 0;
    assign mem_rdata = (mem_read && rd_run == READ_LAT - 1) ? mem[mem_addr[7:2]]
                                                           : ~mem[mem_addr[7:2]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining access cycles, response flag, owner, kill, starve.
    int          m_left;
    bit          m_resp;
    bit          m_dbg;
    bit          m_kill;
    int          m_starve;
    logic [7:0]  m_addr;
    logic [31:0] m_data;

    task automatic model_reset();
        m_left   = 0;
        m_resp   = 0;
        m_dbg    = 0;
        m_kill   = 0;
        m_starve = 0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic model_cycle();
        bit acc, dwin, exp_fr, exp_dr;
        acc    = (m_left == 0);
        dwin   = (m_starve == STARVE_LIMIT) || !f_req_valid;
        exp_fr = acc && f_req_valid && !dwin;
        exp_dr = acc && d_req_valid && dwin;
        check("f_req_ready", 32'(f_req_ready), 32'(exp_fr));
        check("d_req_ready", 32'(d_req_ready), 32'(exp_dr));
        check("mem_read",    32'(mem_read),    32'(m_left > 0));
        check("busy",        32'(busy),        32'(m_left > 0));
        check("mem_addr",    32'(mem_addr),    32'(m_addr));
        check("f_rsp_valid", 32'(f_rsp_valid), 32'(m_resp && !m_dbg && !m_kill));
        check("d_rsp_valid", 32'(d_rsp_valid), 32'(m_resp && m_dbg));
        if (m_resp && !m_dbg && !m_kill) check("f_rsp_data", f_rsp_data, m_data);
        if (m_resp && m_dbg)             check("d_rsp_data", d_rsp_data, m_data);

        if (reset) begin
            model_reset();
        end else begin
            if (!d_req_valid || exp_dr) m_starve = 0;
            else if (acc)               m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
            if (exp_fr || exp_dr) begin
                m_left = READ_LAT;
                m_dbg  = exp_dr;
                m_kill = 0;
                m_addr = exp_dr ? d_req_addr : f_req_addr;
                m_resp = 0;
            end else if (m_left > 0) begin
                if (!m_dbg && f_flush) m_kill = 1;
                m_resp = (m_left == 1);
                if (m_left == 1) m_data = mem[m_addr[7:2]];
                m_left--;
            end else begin
                m_resp = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit fv, input logic [7:0] fa, input bit ff,
                        input bit dv, input logic [7:0] da);
        @(posedge clk);
        #1;
        reset       = rst;
        f_req_valid = fv;
        f_req_addr  = fa;
        f_flush     = ff;
        d_req_valid = dv;
        d_req_addr  = da;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h200f0008;
        mem[1] = 32'hac0f0000;
        reset = 1'b1;
        f_req_valid = 0; f_req_addr = '0; f_flush = 0;
        d_req_valid = 0; d_req_addr = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        idle(1);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_f_rsp",    32'(f_rsp_valid), 32'd0);
        check("rst_d_rsp",    32'(d_rsp_valid), 32'd0);
        check("rst_data",     f_rsp_data, 32'd0);

        // Single fetch
        step(0, 1, 8'h00, 0, 0, 8'h00);
        check("t1_f_ready", 32'(f_req_ready), 32'd1);
        idle(1);
        check("t1_mem_read_c1", 32'(mem_read), 32'd1);
        check("t1_mem_addr_c1", 32'(mem_addr), 32'h00);
        idle(1);
        check("t1_mem_read_c2", 32'(mem_read), 32'd1);
        idle(1);
        check("t1_f_rsp_valid", 32'(f_rsp_valid), 32'd1);
        check("t1_f_rsp_data",  f_rsp_data, 32'h200f0008);
        check("t1_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
        idle(3);

        // Back-to-back fetches
        step(0, 1, 8'h00, 0, 0, 8'h00);
        check("b2b_ready_c0", 32'(f_req_ready), 32'd1);
        step(0, 1, 8'h04, 0, 0, 8'h00);
        check("b2b_ready_c1", 32'(f_req_ready), 32'd0);
        step(0, 1, 8'h04, 0, 0, 8'h00);
        step(0, 1, 8'h04, 0, 0, 8'h00);
        check("b2b_ready_c3", 32'(f_req_ready), 32'd1);
        check("b2b_rsp_c3",   32'(f_rsp_valid), 32'd1);
        check("b2b_data_c3",  f_rsp_data, 32'h200f0008);
        idle(2);
        idle(1);
        check("b2b_rsp_c6",   32'(f_rsp_valid), 32'd1);
        check("b2b_data_c6",  f_rsp_data, 32'hac0f0000);
        idle(3);

        // Starvation: debug wins at the fifth arbitration
        for (int c = 0; c < 16; c++) begin
            step(0, 1, 8'h08, 0, 1, 8'h0c);
            if (c == 0 || c == 3 || c == 6 || c == 9 || c == 15)
                check("starve_f_ready", 32'(f_req_ready), 32'd1);
            if (c == 12) begin
                check("starve_d_ready", 32'(d_req_ready), 32'd1);
                check("starve_f_block", 32'(f_req_ready), 32'd0);
            end
        end
        idle(4);

        // Flush kills the in-flight fetch response only
        step(0, 1, 8'h04, 0, 0, 8'h00);
        check("fl_ready_c0", 32'(f_req_ready), 32'd1);
        step(0, 0, 8'h00, 1, 0, 8'h00);
        check("fl_mem_read_c1", 32'(mem_read), 32'd1);
        idle(1);
        check("fl_mem_read_c2", 32'(mem_read), 32'd1);
        step(0, 1, 8'h00, 0, 0, 8'h00);
        check("fl_rsp_killed", 32'(f_rsp_valid), 32'd0);
        check("fl_ready_c3",   32'(f_req_ready), 32'd1);
        idle(2);
        idle(1);
        check("fl_rsp_c6",  32'(f_rsp_valid), 32'd1);
        check("fl_data_c6", f_rsp_data, 32'h200f0008);
        idle(3);

        // Misaligned debug read
        step(0, 0, 8'h00, 0, 1, 8'h05);
        check("mis_d_ready", 32'(d_req_ready), 32'd1);
        idle(1);
        check("mis_mem_addr", 32'(mem_addr), 32'h05);
        idle(1);
        idle(1);
        check("mis_d_rsp",  32'(d_rsp_valid), 32'd1);
        check("mis_d_data", d_rsp_data, 32'hac0f0000);
        check("mis_f_rsp",  32'(f_rsp_valid), 32'd0);
        idle(3);

        // Reset in the middle of an access
        step(0, 1, 8'h04, 0, 0, 8'h00);
        step(1, 0, 8'h00, 0, 0, 8'h00);
        idle(1);
        check("mid_rst_mem_read", 32'(mem_read), 32'd0);
        check("mid_rst_busy",     32'(busy), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_f_rsp",    32'(f_rsp_valid), 32'd0);
        check("mid_rst_data",     f_rsp_data, 32'd0);
        idle(1);
        check("mid_rst_no_rsp",   32'(f_rsp_valid), 32'd0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 70, 8'($urandom),
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 50, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
